// File: rtl/garbage_receiver_if.sv
// Garbage row insertion handshake between the receiver and the playfield inserter.
// The receiver offers rows as master; the inserter accepts them as slave.
interface garbage_receiver_if;
  logic       insert_valid;
  logic       insert_ready;
  logic [3:0] insert_hole_col;

  modport master (
    output insert_valid,
    output insert_hole_col,
    input  insert_ready
  );

  modport slave (
    input  insert_valid,
    input  insert_hole_col,
    output insert_ready
  );
endinterface

// File: rtl/garbage_receiver.sv
// Holds incoming garbage, cancels it against our outgoing attack and streams rows
// into the playfield after a lock that clears nothing.
module garbage_receiver #(
  parameter int unsigned PLAYFIELD_COLS = 10,
  parameter int unsigned MAX_PENDING    = 20,
  parameter int unsigned INSERT_CAP     = 8,
  parameter logic [6:0]  LFSR_SEED      = 7'h5A
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      i_game_start,
  input  logic                      i_atk_in_valid,
  input  logic [4:0]                i_atk_in_count,
  input  logic                      i_send_valid,
  input  logic [4:0]                i_send_count,
  input  logic                      i_falling_piece_lock,
  input  logic                      i_lines_cleared_en,
  garbage_receiver_if.master        io_insert,
  output logic                      o_send_out_valid,
  output logic [4:0]                o_send_out_count,
  output logic [4:0]                o_pending_count,
  output logic                      o_busy
);

  localparam logic [3:0] ColsW   = 4'(PLAYFIELD_COLS);
  localparam logic [5:0] MaxPend = 6'(MAX_PENDING);
  localparam logic [4:0] InsCap  = 5'(INSERT_CAP);

  typedef enum logic [1:0] {StIdle, StCheck, StInsert} state_e;

  state_e     r_state;
  logic [4:0] r_pending;
  logic [4:0] r_remaining;
  logic [3:0] r_hole;
  logic       r_insert_valid;
  logic       r_send_out_valid;
  logic [4:0] r_send_out_count;
  logic [6:0] r_lfsr;

  logic [5:0] w_atk;
  logic [5:0] w_send;
  logic [5:0] w_base;
  logic [5:0] w_diff;
  logic [4:0] w_residue;
  logic       w_acc;
  logic [4:0] w_pending_next;
  logic [4:0] w_rem_after;
  logic [4:0] w_rem_next;
  logic [4:0] w_burst_len;
  logic [3:0] w_hole_raw;
  logic [3:0] w_hole;

  // Cancel arithmetic: 6 bits so pending + attack never wraps before saturation.
  always_comb begin
    w_atk          = i_atk_in_valid ? {1'b0, i_atk_in_count} : 6'd0;
    w_send         = i_send_valid ? {1'b0, i_send_count} : 6'd0;
    w_acc          = r_insert_valid && io_insert.insert_ready;
    w_base         = {1'b0, r_pending} + w_atk - {5'd0, w_acc};
    w_diff         = 6'd0;
    w_residue      = 5'd0;
    w_pending_next = 5'd0;
    if (w_send >= w_base) begin
      w_residue = 5'(w_send - w_base);
    end else begin
      w_diff         = w_base - w_send;
      w_pending_next = (w_diff > MaxPend) ? 5'(MaxPend) : 5'(w_diff);
    end
  end

  // A cancel mid-burst can shrink the rows still owed below the current count.
  always_comb begin
    w_rem_after = r_remaining - {4'd0, w_acc};
    w_rem_next  = (w_rem_after > w_pending_next) ? w_pending_next : w_rem_after;
    w_burst_len = (w_pending_next > InsCap) ? InsCap : w_pending_next;
    w_hole_raw  = r_lfsr[3:0];
    w_hole      = (w_hole_raw >= ColsW) ? w_hole_raw - ColsW : w_hole_raw;
  end

  // Free-running hole source; deliberately not reseeded by game_start.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state          <= StIdle;
      r_pending        <= 5'd0;
      r_remaining      <= 5'd0;
      r_hole           <= 4'd0;
      r_insert_valid   <= 1'b0;
      r_send_out_valid <= 1'b0;
      r_send_out_count <= 5'd0;
    end else if (i_game_start) begin
      r_state          <= StIdle;
      r_pending        <= 5'd0;
      r_remaining      <= 5'd0;
      r_hole           <= 4'd0;
      r_insert_valid   <= 1'b0;
      r_send_out_valid <= 1'b0;
      r_send_out_count <= 5'd0;
    end else begin
      r_pending <= w_pending_next;
      if (i_send_valid && (w_residue != 5'd0)) begin
        r_send_out_valid <= 1'b1;
        r_send_out_count <= w_residue;
      end else begin
        r_send_out_valid <= 1'b0;
        r_send_out_count <= 5'd0;
      end

      unique case (r_state)
        StIdle: begin
          if (i_falling_piece_lock) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (i_lines_cleared_en || (w_pending_next == 5'd0)) begin
            r_state <= StIdle;
          end else begin
            r_remaining    <= w_burst_len;
            r_hole         <= w_hole;
            r_insert_valid <= 1'b1;
            r_state        <= StInsert;
          end
        end
        StInsert: begin
          if (w_rem_next == 5'd0) begin
            r_remaining    <= 5'd0;
            r_insert_valid <= 1'b0;
            r_state        <= StIdle;
          end else begin
            r_remaining <= w_rem_next;
          end
        end
        default: begin
          r_state        <= StIdle;
          r_insert_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_insert.insert_valid    = r_insert_valid;
  assign io_insert.insert_hole_col = r_hole;
  assign o_send_out_valid          = r_send_out_valid;
  assign o_send_out_count          = r_send_out_count;
  assign o_pending_count           = r_pending;
  assign o_busy                    = (r_state != StIdle);

endmodule

// File: tb/tb_garbage_receiver.sv
// Directed bench for garbage_receiver: cancel arithmetic, bursts, saturation and restart.
module tb_garbage_receiver;

  logic       clk;
  logic       rst_l;
  logic       game_start;
  logic       atk_in_valid;
  logic [4:0] atk_in_count;
  logic       send_valid;
  logic [4:0] send_count;
  logic       falling_piece_lock;
  logic       lines_cleared_en;
  logic       send_out_valid;
  logic [4:0] send_out_count;
  logic [4:0] pending_count;
  logic       busy;

  garbage_receiver_if u_if ();

  garbage_receiver u_dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .i_game_start         (game_start),
    .i_atk_in_valid       (atk_in_valid),
    .i_atk_in_count       (atk_in_count),
    .i_send_valid         (send_valid),
    .i_send_count         (send_count),
    .i_falling_piece_lock (falling_piece_lock),
    .i_lines_cleared_en   (lines_cleared_en),
    .io_insert            (u_if),
    .o_send_out_valid     (send_out_valid),
    .o_send_out_count     (send_out_count),
    .o_pending_count      (pending_count),
    .o_busy               (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference hole source: x^7+x^6+1 Fibonacci, seeded 7'h5A on reset.
  logic [6:0] m_lfsr;
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) m_lfsr <= 7'h5A;
    else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] hole_of(input logic [6:0] v);
    logic [3:0] h;
    h = v[3:0];
    return (h >= 4'd10) ? h - 4'd10 : h;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic attack(input logic [4:0] n);
    atk_in_valid = 1'b1;
    atk_in_count = n;
    step();
    atk_in_valid = 1'b0;
    atk_in_count = 5'd0;
  endtask

  task automatic send(input logic [4:0] n);
    send_valid = 1'b1;
    send_count = n;
    step();
    send_valid = 1'b0;
    send_count = 5'd0;
  endtask

  // Lock now; returns in CHECK with the hole the DUT will latch on the next edge.
  task automatic lock(output logic [3:0] exp_hole);
    falling_piece_lock = 1'b1;
    step();
    falling_piece_lock = 1'b0;
    exp_hole = hole_of(m_lfsr);
  endtask

  // From CHECK with ready high: count offered rows, checking the hole on each.
  task automatic run_burst(input string tag, input logic [3:0] exp_hole, output int rows);
    rows = 0;
    step();
    for (int i = 0; i < 32 && u_if.insert_valid === 1'b1; i++) begin
      rows++;
      chk({tag, "_hole"}, 32'(u_if.insert_hole_col), 32'(exp_hole));
      step();
    end
    chk({tag, "_done"}, 32'(u_if.insert_valid), 32'd0);
  endtask

  logic [3:0] hole_a;
  logic [3:0] hole_b;
  int         rows;

  initial begin
    rst_l              = 1'b0;
    game_start         = 1'b0;
    atk_in_valid       = 1'b0;
    atk_in_count       = 5'd0;
    send_valid         = 1'b0;
    send_count         = 5'd0;
    falling_piece_lock = 1'b0;
    lines_cleared_en   = 1'b0;
    u_if.insert_ready  = 1'b0;
    step();
    step();
    chk("rst_pending", 32'(pending_count), 32'd0);
    chk("rst_ins_valid", 32'(u_if.insert_valid), 32'd0);
    chk("rst_hole", 32'(u_if.insert_hole_col), 32'd0);
    chk("rst_so_valid", 32'(send_out_valid), 32'd0);
    chk("rst_so_count", 32'(send_out_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_l = 1'b1;
    step();

    // Four lines in, one clean lock, four rows out.
    attack(5'd4);
    chk("t1_pending", 32'(pending_count), 32'd4);
    u_if.insert_ready = 1'b1;
    lock(hole_a);
    chk("t1_check_busy", 32'(busy), 32'd1);
    chk("t1_check_noins", 32'(u_if.insert_valid), 32'd0);
    run_burst("t1", hole_a, rows);
    chk("t1_rows", 32'(rows), 32'd4);
    chk("t1_pending_end", 32'(pending_count), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Cancel: 3 pending vs 5 sent leaves 2 forwarded; 3 vs 2 leaves 1 held.
    attack(5'd3);
    send(5'd5);
    chk("t2_pending0", 32'(pending_count), 32'd0);
    chk("t2_so_valid", 32'(send_out_valid), 32'd1);
    chk("t2_so_count", 32'(send_out_count), 32'd2);
    step();
    chk("t2_so_drop", 32'(send_out_valid), 32'd0);
    attack(5'd3);
    send(5'd2);
    chk("t2_pending1", 32'(pending_count), 32'd1);
    chk("t2_so_none", 32'(send_out_valid), 32'd0);
    send(5'd1);
    chk("t2_clear", 32'(pending_count), 32'd0);

    // Twelve pending: capped burst of 8, then the remaining 4.
    attack(5'd12);
    chk("t3_pending", 32'(pending_count), 32'd12);
    lock(hole_a);
    run_burst("t3a", hole_a, rows);
    chk("t3a_rows", 32'(rows), 32'd8);
    chk("t3a_pending", 32'(pending_count), 32'd4);
    lock(hole_b);
    run_burst("t3b", hole_b, rows);
    chk("t3b_rows", 32'(rows), 32'd4);
    chk("t3b_pending", 32'(pending_count), 32'd0);

    // Lock that clears lines keeps garbage held.
    attack(5'd5);
    lines_cleared_en = 1'b1;
    lock(hole_a);
    step();
    lines_cleared_en = 1'b0;
    chk("t4_noins", 32'(u_if.insert_valid), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_pending", 32'(pending_count), 32'd5);
    send(5'd5);
    chk("t4_clear", 32'(pending_count), 32'd0);
    chk("t4_so_none", 32'(send_out_valid), 32'd0);

    // Stall with ready low, then a cancel shrinks the burst from 6 to 2.
    attack(5'd6);
    u_if.insert_ready = 1'b0;
    lock(hole_a);
    step();
    chk("t5_valid", 32'(u_if.insert_valid), 32'd1);
    chk("t5_hole", 32'(u_if.insert_hole_col), 32'(hole_a));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_valid", 32'(u_if.insert_valid), 32'd1);
      chk("t5_stall_hole", 32'(u_if.insert_hole_col), 32'(hole_a));
    end
    send(5'd4);
    chk("t5_cancel_pending", 32'(pending_count), 32'd2);
    chk("t5_cancel_valid", 32'(u_if.insert_valid), 32'd1);
    u_if.insert_ready = 1'b1;
    rows = 0;
    for (int i = 0; i < 16 && u_if.insert_valid === 1'b1; i++) begin
      rows++;
      step();
    end
    chk("t5_rows", 32'(rows), 32'd2);
    chk("t5_pending_end", 32'(pending_count), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // Saturation at 20, then game_start aborts a burst.
    attack(5'd15);
    chk("t6_pending15", 32'(pending_count), 32'd15);
    attack(5'd10);
    chk("t6_saturate", 32'(pending_count), 32'd20);
    lock(hole_a);
    step();
    chk("t6_ins_valid", 32'(u_if.insert_valid), 32'd1);
    chk("t6_pending20", 32'(pending_count), 32'd20);
    step();
    step();
    chk("t6_pending18", 32'(pending_count), 32'd18);
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("t6_gs_pending", 32'(pending_count), 32'd0);
    chk("t6_gs_ins_valid", 32'(u_if.insert_valid), 32'd0);
    chk("t6_gs_busy", 32'(busy), 32'd0);
    chk("t6_gs_hole", 32'(u_if.insert_hole_col), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/garbage_receiver.md
Name: garbage_receiver

Overview:
- Receiving end of the attack path: accepts garbage-line attacks from the opponent and holds them in a pending count.
- Cancels pending garbage against our own outgoing attack; only the residue is forwarded to the opponent.
- On a piece lock that clears no lines, streams garbage rows into the playfield inserter with a valid/ready handshake. All rows in one burst share a single hole column.
- Sits between the inter-board link, the lines-sent logic, and the playfield storage.

Parameters:
- PLAYFIELD_COLS, 10, playfield width; hole column range is 0..PLAYFIELD_COLS-1.
- MAX_PENDING, 20, saturation limit of the pending garbage count.
- INSERT_CAP, 8, maximum rows inserted per lock.
- LFSR_SEED, 7'h5A, nonzero reset value of the hole LFSR.

Ports:
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- game_start  in  1  synchronous clear of all state
- atk_in_valid  in  1  opponent attack arrives this cycle
- atk_in_count  in  5  lines in that attack
- send_valid  in  1  our attack computed this cycle
- send_count  in  5  lines of our attack (pre-cancel)
- falling_piece_lock  in  1  piece locked this cycle
- lines_cleared_en  in  1  lock cleared ≥1 line; sampled in CHECK
- insert_valid  out  1  garbage row offered
- insert_ready  in  1  inserter accepts row
- insert_hole_col  out  4  hole column for the offered row
- send_out_valid  out  1  residual attack to opponent
- send_out_count  out  5  residual lines after cancel
- pending_count  out  5  queued garbage lines
- busy  out  1  state != IDLE

Behaviour:
- Reset and game_start values: pending_count=0, insert_valid=0, send_out_valid=0, send_out_count=0, insert_hole_col=0, state=IDLE.
  - LFSR resets to LFSR_SEED on rst_l only; game_start does not reseed it.
  - game_start mid-burst returns to IDLE next cycle; any row not yet accepted is dropped.
- Pending and cancel arithmetic, every cycle, 6-bit internal:
  - a = atk_in_valid ? atk_in_count : 0
  - s = send_valid ? send_count : 0
  - acc = insert_valid && insert_ready
  - base = pending + a - acc
  - If s ≥ base: pending_next=0, residue = s - base.
  - Else: pending_next = min(base - s, MAX_PENDING), residue = 0.
  - Saturation discards excess silently.
- Residue output (registered, 1-cycle latency):
  - send_out_valid=1 and send_out_count=residue when send_valid was set and residue>0.
  - Otherwise send_out_valid=0.
- FSM states and transitions:
  - IDLE: on falling_piece_lock → CHECK.
  - CHECK (one cycle after the lock, when the clear flag is valid):
    - If lines_cleared_en, or pending_next==0 → IDLE. No insert; garbage stays held.
    - Else remaining = min(pending_next, INSERT_CAP), latch insert_hole_col from the LFSR → INSERT.
  - INSERT:
    - insert_valid=1; insert_hole_col stays constant for the whole burst.
    - On acc: remaining -= 1.
    - Each cycle: remaining = min(remaining, pending_next), so cancels during a burst shrink it.
    - remaining reaches 0 → IDLE, with insert_valid deasserting that same edge.
    - Attacks arriving during INSERT add to pending only, never to the current burst.
    - falling_piece_lock during INSERT is ignored.
- Handshake rules:
  - insert_valid, once high, stays high until the row is accepted or remaining hits 0 via cancel.
  - insert_hole_col is stable while insert_valid is high.
- Hole LFSR:
  - 7-bit Fibonacci, taps x^7+x^6+1, free-running every cycle.
  - h = lfsr[3:0]; hole = (h ≥ PLAYFIELD_COLS) ? h - PLAYFIELD_COLS : h.

Test Plan:
- Reset, then atk 4 lines; lock with lines_cleared_en=0 → CHECK then INSERT; 4 accepts with ready=1.
  - Required: insert_valid high for exactly 4 cycles, same hole each row, pending 4→0, back to IDLE.
- pending=3; send_valid with send_count=5 → pending=0, next cycle send_out_valid=1, send_out_count=2. A second case with send_count=2 → pending=1, send_out_valid=0.
- pending=12; lock without clear → burst of 8 rows, pending=4 afterwards. A second lock → burst of 4 with a new hole column.
- pending=5; lock with lines_cleared_en=1 → no insert_valid, pending stays 5.
- INSERT with remaining=6 and insert_ready held low 3 cycles → insert_valid and hole stable throughout. Then send_count=4 arrives → remaining drops to 2; only 2 rows accepted.
- atk 15 then atk 10 → pending saturates at 20. game_start mid-burst → pending=0, insert_valid=0 the next cycle.
